// File: rtl/puf_session_if.sv
// Host/PUF-side handshake bundle for puf_session_ctrl: UART rx/tx control,
// challenge register write port, PUF evaluation handshake and response FIFO.
interface puf_session_if #(
    parameter int DATA_W     = 8,
    parameter int CHAL_BYTES = 4
);
    localparam int CIDX_W = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_enable;
    logic              tx_busy;
    logic              tx_start;
    logic [1:0]        tx_sel;
    logic              chal_we;
    logic [CIDX_W-1:0] chal_idx;
    logic              puf_enable;
    logic              puf_done;
    logic              fifo_empty;
    logic              fifo_re;
    logic              sub_reset;
    logic              err;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, tx_busy, puf_done, fifo_empty,
        output rx_enable, tx_start, tx_sel, chal_we, chal_idx, puf_enable,
               fifo_re, sub_reset, err, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, puf_done, fifo_empty,
        input  rx_enable, tx_start, tx_sel, chal_we, chal_idx, puf_enable,
               fifo_re, sub_reset, err, busy
    );
endinterface

// File: rtl/puf_session_ctrl.sv
// UART-side session controller for the PUF: opcode decode, challenge assembly,
// evaluation launch with timeout, response streaming and error reporting.
module puf_session_ctrl #(
    parameter int              DATA_W      = 8,
    parameter int              CHAL_BYTES  = 4,
    parameter int              RESP_WORDS  = 8,
    parameter int              TIMEOUT_CYC = 100000,
    parameter logic [DATA_W-1:0] CMD_ID    = 8'h49,
    parameter logic [DATA_W-1:0] CMD_CHAL  = 8'h43,
    parameter logic [DATA_W-1:0] ERR_BYTE  = 8'hEE
) (
    input logic           clk,
    input logic           reset,
    puf_session_if.master bus
);
    localparam int CIDX_W = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;
    localparam int WORD_W = (RESP_WORDS > 0) ? $clog2(RESP_WORDS + 1) : 1;
    localparam int TOUT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    // The error byte must never be mistaken for a valid opcode by the host.
    if ((ERR_BYTE == CMD_ID) || (ERR_BYTE == CMD_CHAL) || (CMD_ID == CMD_CHAL)) begin : g_bad_opcodes
        $error("puf_session_ctrl: opcodes and error byte must be distinct");
    end

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_SEND_ID, S_GUARD, S_RX_CHAL, S_EVAL,
        S_LOAD_RESP, S_SEND_RESP_WAIT, S_SEND_RESP, S_SEND_ERR
    } state_t;

    state_t            state_q, state_d, tgt_q, tgt_d;
    logic [CIDX_W-1:0] idx_q, idx_d, chal_idx_q, chal_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic [1:0]        tx_sel_q, tx_sel_d;
    logic              err_q, err_d, tx_start_q, tx_start_d, chal_we_q, chal_we_d;
    logic              fifo_re_q, fifo_re_d, sub_reset_q, sub_reset_d;
    logic              rx_enable_q, rx_enable_d, busy_q, busy_d, puf_enable_q, puf_enable_d;

    logic              tout_hit_s;
    logic [TOUT_W-1:0] tout_sat_s;

    assign tout_hit_s = (tout_q == TOUT_W'(TIMEOUT_CYC - 1));
    assign tout_sat_s = (tout_q == {TOUT_W{1'b1}}) ? tout_q : (tout_q + 1'b1);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        idx_d       = idx_q;
        chal_idx_d  = chal_idx_q;
        word_d      = word_q;
        tout_d      = tout_q;
        err_d       = err_q;
        tx_sel_d    = tx_sel_q;
        tx_start_d  = 1'b0;
        chal_we_d   = 1'b0;
        fifo_re_d   = 1'b0;
        sub_reset_d = 1'b0;
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_ID) begin
                        err_d   = 1'b0;
                        state_d = S_SEND_ID;
                    end else if (bus.rx_data == CMD_CHAL) begin
                        err_d      = 1'b0;
                        idx_d      = '0;
                        chal_idx_d = '0;
                        tout_d     = '0;
                        state_d    = S_RX_CHAL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SEND_ERR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_ID: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_sel_d   = 2'd0;
                    tgt_d      = S_IDLE;
                    state_d    = S_GUARD;
                end else begin
                    state_d = S_SEND_ID;
                end
            end
            S_GUARD: state_d = tgt_q;
            S_RX_CHAL: begin
                if (bus.rx_valid) begin
                    chal_we_d  = 1'b1;
                    chal_idx_d = idx_q;
                    tout_d     = '0;
                    if (idx_q == CIDX_W'(CHAL_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (tout_hit_s) begin
                    // A stalled host loses its partial challenge.
                    err_d      = 1'b1;
                    idx_d      = '0;
                    chal_idx_d = '0;
                    state_d    = S_SEND_ERR;
                end else begin
                    tout_d = tout_sat_s;
                end
            end
            S_EVAL: begin
                if (bus.puf_done) begin
                    word_d  = '0;
                    state_d = S_LOAD_RESP;
                end else if (tout_hit_s) begin
                    err_d       = 1'b1;
                    sub_reset_d = 1'b1;
                    state_d     = S_SEND_ERR;
                end else begin
                    tout_d = tout_sat_s;
                end
            end
            S_LOAD_RESP: begin
                if (bus.fifo_empty) begin
                    err_d       = 1'b1;
                    sub_reset_d = 1'b1;
                    state_d     = S_SEND_ERR;
                end else begin
                    fifo_re_d = 1'b1;
                    state_d   = S_SEND_RESP_WAIT;
                end
            end
            S_SEND_RESP_WAIT: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_sel_d   = 2'd1;
                    word_d     = word_q + 1'b1;
                    tgt_d      = S_SEND_RESP;
                    state_d    = S_GUARD;
                end else begin
                    state_d = S_SEND_RESP_WAIT;
                end
            end
            S_SEND_RESP: begin
                if (bus.tx_busy) begin
                    state_d = S_SEND_RESP;
                end else if (word_q == WORD_W'(RESP_WORDS)) begin
                    // Surplus words are flushed silently; only the flag reports it.
                    state_d = S_IDLE;
                    if (!bus.fifo_empty) begin
                        sub_reset_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = S_LOAD_RESP;
                end
            end
            S_SEND_ERR: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_sel_d   = 2'd2;
                    tgt_d      = S_IDLE;
                    state_d    = S_GUARD;
                end else begin
                    state_d = S_SEND_ERR;
                end
            end
            default: state_d = S_RESET;
        endcase
        rx_enable_d  = (state_d == S_IDLE) || (state_d == S_RX_CHAL);
        busy_d       = (state_d != S_IDLE);
        puf_enable_d = (state_d == S_EVAL);
    end

    // State and output registers; reset holds everything low except sub_reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            tgt_q        <= S_IDLE;
            idx_q        <= '0;
            chal_idx_q   <= '0;
            word_q       <= '0;
            tout_q       <= '0;
            err_q        <= 1'b0;
            tx_sel_q     <= 2'd0;
            tx_start_q   <= 1'b0;
            chal_we_q    <= 1'b0;
            fifo_re_q    <= 1'b0;
            sub_reset_q  <= 1'b1;
            rx_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            puf_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            idx_q        <= idx_d;
            chal_idx_q   <= chal_idx_d;
            word_q       <= word_d;
            tout_q       <= tout_d;
            err_q        <= err_d;
            tx_sel_q     <= tx_sel_d;
            tx_start_q   <= tx_start_d;
            chal_we_q    <= chal_we_d;
            fifo_re_q    <= fifo_re_d;
            sub_reset_q  <= sub_reset_d;
            rx_enable_q  <= rx_enable_d;
            busy_q       <= busy_d;
            puf_enable_q <= puf_enable_d;
        end
    end

    assign bus.rx_enable  = rx_enable_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_sel     = tx_sel_q;
    assign bus.chal_we    = chal_we_q;
    assign bus.chal_idx   = chal_idx_q;
    assign bus.puf_enable = puf_enable_q;
    assign bus.fifo_re    = fifo_re_q;
    assign bus.sub_reset  = sub_reset_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_puf_session_ctrl.sv
// Directed bench for puf_session_ctrl with a small UART-busy, FIFO-level and
// event-logging environment; TIMEOUT_CYC is shortened to 50.
module tb_puf_session_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    puf_session_if #(.DATA_W(8), .CHAL_BYTES(4)) bus ();

    puf_session_ctrl #(
        .DATA_W(8), .CHAL_BYTES(4), .RESP_WORDS(8), .TIMEOUT_CYC(50),
        .CMD_ID(8'h49), .CMD_CHAL(8'h43), .ERR_BYTE(8'hEE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0, errors = 0;
    int busy_cnt = 0, tx_cnt = 0, sel1_cnt = 0, re_cnt = 0, we_cnt = 0;
    int sr_cnt = 0, overlap_cnt = 0, fifo_top = 0;
    logic [1:0] last_sel = 2'd3;
    logic [1:0] chal_log [0:15];

    assign bus.tx_busy    = (busy_cnt != 0);
    assign bus.fifo_empty = (fifo_top <= re_cnt);

    // UART busy model, FIFO read counting and event logging.
    always @(posedge clk) begin
        if (bus.tx_start) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (bus.tx_start) begin
            tx_cnt   <= tx_cnt + 1;
            last_sel <= bus.tx_sel;
            if (bus.tx_sel == 2'd1) sel1_cnt <= sel1_cnt + 1;
            if (bus.tx_busy) overlap_cnt <= overlap_cnt + 1;
        end
        if (bus.fifo_re) re_cnt <= re_cnt + 1;
        if (bus.chal_we) begin
            chal_log[we_cnt[3:0]] <= bus.chal_idx;
            we_cnt <= we_cnt + 1;
        end
        if (bus.sub_reset && !reset) sr_cnt <= sr_cnt + 1;
    end

    function automatic logic [11:0] status();
        return {bus.rx_enable, bus.tx_start, bus.tx_sel, bus.chal_we, bus.chal_idx,
                bus.puf_enable, bus.fifo_re, bus.sub_reset, bus.err, bus.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int k = 0;
        while (tx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_cnt), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_puf(input string tag, input int budget);
        int k = 0;
        while (!bus.puf_enable && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.puf_enable), 32'd1);
    endtask

    task automatic pulse_done();
        bus.puf_done = 1'b1;
        @(negedge clk);
        bus.puf_done = 1'b0;
    endtask

    initial begin
        int base, rb, s1, wb, sr0, cyc, txr;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.puf_done = 1'b0;
        tick(3);
        chk("reset_outputs", 32'(status()), 32'h004);
        reset = 1'b0;
        tick(3);
        chk("idle_after_reset", 32'(status()), 32'h800);
        chk("sub_reset_release", 32'(sr_cnt), 32'd1);

        // ID request
        base = tx_cnt;
        send(8'h49);
        wait_tx("id_tx", base + 1, 30);
        chk("id_sel", 32'(last_sel), 32'd0);
        wait_idle("id_idle", 30);
        tick(10);
        chk("id_single", 32'(tx_cnt), 32'(base + 1));
        chk("id_err", 32'(bus.err), 32'd0);

        // puf_done outside EVAL does nothing
        pulse_done();
        tick(2);
        chk("done_ignored", 32'(status()), 32'h800);

        // Full session
        base = tx_cnt; rb = re_cnt; s1 = sel1_cnt; wb = we_cnt;
        fifo_top = re_cnt + 8;
        send(8'h43); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        tick(1);
        chk("chal_we_count", 32'(we_cnt - wb), 32'd4);
        chk("chal_idx_seq", 32'({chal_log[wb], chal_log[wb+1], chal_log[wb+2], chal_log[wb+3]}), 32'h1B);
        wait_puf("puf_on", 10);
        tick(5);
        chk("puf_held", 32'(bus.puf_enable), 32'd1);
        pulse_done();
        wait_tx("resp_tx", base + 8, 400);
        wait_idle("resp_idle", 50);
        chk("resp_fifo_re", 32'(re_cnt - rb), 32'd8);
        chk("resp_sel1", 32'(sel1_cnt - s1), 32'd8);
        chk("resp_last_sel", 32'(last_sel), 32'd1);
        chk("resp_err", 32'(bus.err), 32'd0);
        chk("resp_no_overlap", 32'(overlap_cnt), 32'd0);
        chk("resp_no_subreset", 32'(sr_cnt), 32'd1);

        // Unknown opcode, then ID clears err
        base = tx_cnt;
        send(8'h00);
        tick(1);
        chk("badop_err", 32'(bus.err), 32'd1);
        wait_tx("badop_tx", base + 1, 30);
        chk("badop_sel", 32'(last_sel), 32'd2);
        wait_idle("badop_idle", 30);
        send(8'h49);
        chk("id_clears_err", 32'(bus.err), 32'd0);
        wait_tx("id2_tx", base + 2, 30);
        chk("id2_sel", 32'(last_sel), 32'd0);
        wait_idle("id2_idle", 30);

        // Challenge timeout after two bytes
        base = tx_cnt; wb = we_cnt;
        send(8'h43); send(8'h11); send(8'h22);
        cyc = 0;
        while (!bus.err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", 32'(cyc), 32'd50);
        chk("timeout_idx", 32'(bus.chal_idx), 32'd0);
        chk("timeout_we", 32'(we_cnt - wb), 32'd2);
        wait_tx("timeout_tx", base + 1, 30);
        chk("timeout_sel", 32'(last_sel), 32'd2);
        wait_idle("timeout_idle", 30);

        // FIFO underflow: 5 of 8 words available
        base = tx_cnt; rb = re_cnt; s1 = sel1_cnt; sr0 = sr_cnt;
        fifo_top = re_cnt + 5;
        send(8'h43);
        chk("chal_clears_err", 32'(bus.err), 32'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        wait_puf("uf_puf_on", 10);
        pulse_done();
        wait_tx("uf_tx", base + 6, 600);
        wait_idle("uf_idle", 50);
        chk("uf_fifo_re", 32'(re_cnt - rb), 32'd5);
        chk("uf_sel1", 32'(sel1_cnt - s1), 32'd5);
        chk("uf_last_sel", 32'(last_sel), 32'd2);
        chk("uf_err", 32'(bus.err), 32'd1);
        chk("uf_subreset", 32'(sr_cnt - sr0), 32'd1);

        // Reset in the middle of the response stream
        base = tx_cnt; sr0 = sr_cnt;
        fifo_top = re_cnt + 8;
        send(8'h43); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        wait_puf("mid_puf_on", 10);
        pulse_done();
        wait_tx("mid_tx3", base + 3, 300);
        reset = 1'b1;
        tick(1);
        chk("mid_reset_outputs", 32'(status()), 32'h004);
        txr = tx_cnt;
        tick(1);
        reset = 1'b0;
        tick(40);
        chk("mid_no_more_tx", 32'(tx_cnt), 32'(txr));
        chk("mid_subreset_once", 32'(sr_cnt - sr0), 32'd1);
        chk("mid_idle", 32'(status()), 32'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/puf_session_ctrl.md
Name: puf_session_ctrl

Overview:
- Parametrised successor of the single-byte PUF control FSM.
- Runs the UART-side protocol between host and PUF core:
  - decodes command bytes (ID request, challenge load);
  - assembles a multi-byte challenge;
  - launches PUF evaluation;
  - streams RESP_WORDS response words out of the response FIFO.
- Adds timeouts, response-count checking and an error byte back to the host.
- Sits between uart_rx/uart_tx, the challenge register file, the PUF evaluation FSM and the response FIFO.

Parameters:
- DATA_W, 8, UART data width in bits.
- CHAL_BYTES, 4, challenge bytes following CMD_CHAL (≥1).
- RESP_WORDS, 8, FIFO words transmitted per evaluation (≥1).
- TIMEOUT_CYC, 100000, max cycles waiting for a challenge byte or puf_done.
- CMD_ID, 8'h49, ID-request opcode.
- CMD_CHAL, 8'h43, challenge opcode.
- ERR_BYTE, 8'hEE, error code transmitted on a fault.

Ports:
- clk, in, 1, global clock.
- reset, in, 1, reset, synchronous, active-high.
- rx_data, in, DATA_W, received byte.
- rx_valid, in, 1, one-cycle strobe: rx_data valid.
- rx_enable, out, 1, reception enabled.
- tx_busy, in, 1, UART transmitter busy.
- tx_start, out, 1, one-cycle transmit pulse.
- tx_sel, out, 2, tx source mux: 0=ID, 1=FIFO, 2=ERR_BYTE.
- chal_we, out, 1, write rx_data into challenge register.
- chal_idx, out, $clog2(CHAL_BYTES) (min 1), challenge byte index.
- puf_enable, out, 1, held high during evaluation.
- puf_done, in, 1, evaluation complete.
- fifo_empty, in, 1, response FIFO empty.
- fifo_re, out, 1, response FIFO read strobe.
- sub_reset, out, 1, reset for UART, PUF FSM and FIFO.
- err, out, 1, sticky fault flag; cleared by the next valid command.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- Output timing:
  - All outputs are registered.
  - All strobes are single-cycle.
  - While reset is high, every output is 0 except sub_reset=1.
- RESET:
  - sub_reset=1 for exactly 1 cycle after reset deasserts.
  - Then IDLE.
- IDLE:
  - rx_enable=1.
  - On rx_valid with rx_data==CMD_ID: clear err, go SEND_ID.
  - On rx_valid with ==CMD_CHAL: clear err, zero chal_idx and the timeout counter, go RX_CHAL.
  - Any other byte: set err, go SEND_ERR.
- SEND_ID: when tx_busy==0, pulse tx_start with tx_sel=0, then GUARD.
- GUARD:
  - One cycle in which tx_busy is ignored, giving the UART time to raise busy.
  - Then returns to the pending target: IDLE after ID/ERR, SEND_RESP after a response word.
- RX_CHAL:
  - rx_enable=1.
  - Each rx_valid: chal_we=1 with the current chal_idx, increment idx, reset timeout.
  - On the byte at idx==CHAL_BYTES-1: go EVAL, timeout counter zeroed.
  - Timeout counter reaching TIMEOUT_CYC-1 without a byte: set err, go SEND_ERR. Partial challenge is discarded (idx zeroed).
- EVAL:
  - puf_enable=1; rx bytes ignored.
  - On puf_done: go LOAD_RESP with word counter=0.
  - Timeout: set err, pulse sub_reset for 1 cycle, go SEND_ERR.
- LOAD_RESP:
  - fifo_empty==1: set err, pulse sub_reset, go SEND_ERR (underflow).
  - Otherwise pulse fifo_re; FIFO output is valid the next cycle; go SEND_RESP_WAIT.
- SEND_RESP_WAIT: when tx_busy==0, pulse tx_start with tx_sel=1, increment word counter, go GUARD with target SEND_RESP.
- SEND_RESP (after guard):
  - When tx_busy==0 and counter==RESP_WORDS: go IDLE. If fifo_empty==0 here, pulse sub_reset (flush surplus) and set err; no error byte is sent.
  - Otherwise go LOAD_RESP.
- SEND_ERR: when tx_busy==0, pulse tx_start with tx_sel=2, go GUARD with target IDLE.
- tx_sel value is held from the tx_start cycle until the next tx_start.
- Counter widths:
  - Word counter is $clog2(RESP_WORDS+1) bits.
  - Timeout counter is $clog2(TIMEOUT_CYC) bits and saturates.
- Synchronous reset in any state returns to RESET next cycle; in-flight UART bytes are abandoned.
- puf_done asserted outside EVAL is ignored.

Test Plan:
- ID request: reset, send 8'h49 with tx_busy idle → exactly one tx_start with tx_sel=0, then IDLE, err=0.
- Full session: 8'h43 + bytes 11,22,33,44 → chal_we ×4 with idx 0..3; puf_enable until puf_done; FIFO preloaded with 8 words → 8 fifo_re, 8 tx_start with tx_sel=1, each tx_start after tx_busy falls; back to IDLE.
- Challenge timeout: TIMEOUT_CYC=50, send 8'h43 + 2 bytes then silence → err=1 at cycle 50 after the last byte; one tx_start with tx_sel=2; chal_idx=0.
- Underflow: FIFO holds 5 words, RESP_WORDS=8 → 5 words sent, then sub_reset pulse, err=1, ERR_BYTE sent.
- Unknown opcode 8'h00 → ERR_BYTE sent; a following 8'h49 clears err and sends ID.
- Reset asserted mid-SEND_RESP (word 3) → all strobes 0 next cycle; sub_reset pulses once after release; no further tx_start.
